// File: rtl/ets_pkg.sv
// Shared types for the ETS capture sequencer: FSM states and one-hot write-buffer ID decode.
package ets_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      CAPTURE,
      NEXT,
      HANDOFF,
      RELEASE
   } state_e;

   localparam logic [2:0] BUF0 = 3'b001;
   localparam logic [2:0] BUF1 = 3'b010;
   localparam logic [2:0] BUF2 = 3'b100;

   typedef struct packed {
      logic       valid;
      logic [1:0] idx;
   } buf_idx_t;

   // Map a one-hot buffer ID to its index; valid drops for any non-one-hot code.
   function automatic buf_idx_t onehot_to_idx(input logic [2:0] id);
      buf_idx_t r;
      r.valid = 1'b1;
      r.idx   = 2'd0;
      case (id)
         BUF0:    r.idx = 2'd0;
         BUF1:    r.idx = 2'd1;
         BUF2:    r.idx = 2'd2;
         default: r.valid = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ets_addr_gen.sv
// Sample/phase counters and interleaved write address: idx*SAMPLES*PHASES + k*PHASES + phase.
module ets_addr_gen #(
   parameter int unsigned SAMPLES = 64,
   parameter int unsigned PHASES  = 16,
   parameter int unsigned ADDR_W  = 12
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       idx_load_i,
   input  logic [1:0]                 idx_i,
   input  logic                       k_inc_i,
   input  logic                       phase_inc_i,
   input  logic                       phase_clr_i,
   output logic                       k_last_o,
   output logic                       phase_last_o,
   output logic [$clog2(PHASES)-1:0]  phase_o,
   output logic [ADDR_W-1:0]          addr_o
);

   localparam int unsigned KW = $clog2(SAMPLES);
   localparam int unsigned PW = $clog2(PHASES);

   logic [KW-1:0]     k_q, k_d;
   logic [PW-1:0]     phase_q, phase_d;
   logic [1:0]        idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   assign k_last_o     = (k_q == KW'(SAMPLES - 1));
   assign phase_last_o = (phase_q == PW'(PHASES - 1));
   assign phase_o      = phase_q;
   assign addr_o       = addr_q;

   // Address is precomputed from the next counter values so it is registered when used.
   always_comb begin
      k_d     = k_q;
      phase_d = phase_q;
      idx_d   = idx_q;
      if (idx_load_i) idx_d = idx_i;
      if (k_inc_i) k_d = k_last_o ? '0 : k_q + KW'(1);
      if (phase_clr_i) phase_d = '0;
      else if (phase_inc_i) phase_d = phase_q + PW'(1);
      addr_d = ADDR_W'(idx_d) * ADDR_W'(SAMPLES * PHASES)
             + ADDR_W'(k_d) * ADDR_W'(PHASES)
             + ADDR_W'(phase_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         k_q     <= '0;
         phase_q <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
      end else begin
         k_q     <= k_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
      end
   end

endmodule

// File: rtl/ets_capture_sequencer.sv
// ETS frame capture sequencer: phase-stepped trigger-aligned bursts into the triple buffer.
// Optional trigger-wait timeout is built when ETS_TRIG_TIMEOUT_EN is defined.
module ets_capture_sequencer
   import ets_pkg::*;
#(
   parameter int unsigned SAMPLES        = 64,
   parameter int unsigned PHASES         = 16,
   parameter int unsigned ADDR_W         = 12,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       trigger,
   input  logic                       sample_valid,
   input  logic [2:0]                 w_buffer_id,
   input  logic                       w_frame_ready,
   output logic                       w_request,
   output logic                       wr_en,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic [$clog2(PHASES)-1:0]  phase,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       id_error
`ifdef ETS_TRIG_TIMEOUT_EN
   ,output logic                      trig_timeout
`endif
);

   if ((64'd1 << ADDR_W) < 64'(3 * SAMPLES * PHASES) || SAMPLES < 2 || PHASES < 2
       || (PHASES & (PHASES - 1)) != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
      $error("ets_capture_sequencer: illegal parameter set");
   end

   state_e   state_q;
   logic     idx_ok_q;
   buf_idx_t id_dec;
   logic     id_sample;
   logic     k_last;
   logic     phase_last;
   logic     phase_inc;
   logic     phase_clr;
   logic     tmo_hit;

   assign id_dec    = onehot_to_idx(w_buffer_id);
   assign wr_en     = (state_q == CAPTURE) && sample_valid;
   // Buffer ID is sampled on entry to ARM and re-sampled every ARM cycle until it decodes.
   assign id_sample = ((state_q == IDLE) && start)
                   || ((state_q == ARM) && !idx_ok_q)
                   || ((state_q == RELEASE) && !w_frame_ready);
   assign phase_inc = (state_q == NEXT) && !phase_last;
   assign phase_clr = (state_q == RELEASE) && !w_frame_ready;

`ifdef ETS_TRIG_TIMEOUT_EN
   logic [31:0] tmo_cnt_q;

   assign tmo_hit = (state_q == ARM) && idx_ok_q && !trigger
                 && (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt_q    <= '0;
         trig_timeout <= 1'b0;
      end else begin
         if ((state_q == ARM) && idx_ok_q && !trigger && !tmo_hit) tmo_cnt_q <= tmo_cnt_q + 32'd1;
         else tmo_cnt_q <= '0;
         if (tmo_hit) trig_timeout <= 1'b1;
         else if ((state_q == IDLE) && !start) trig_timeout <= 1'b0;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   ets_addr_gen #(
      .SAMPLES (SAMPLES),
      .PHASES  (PHASES),
      .ADDR_W  (ADDR_W)
   ) u_addr_gen (
      .clk          (clk),
      .reset        (reset),
      .idx_load_i   (id_sample && id_dec.valid),
      .idx_i        (id_dec.idx),
      .k_inc_i      (wr_en),
      .phase_inc_i  (phase_inc),
      .phase_clr_i  (phase_clr),
      .k_last_o     (k_last),
      .phase_last_o (phase_last),
      .phase_o      (phase),
      .addr_o       (wr_addr)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_ok_q   <= 1'b0;
         w_request  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         id_error   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (id_sample) begin
            idx_ok_q <= id_dec.valid;
            if (!id_dec.valid) id_error <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= ARM;
                  busy    <= 1'b1;
               end
            end
            ARM: begin
               if (idx_ok_q && trigger) state_q <= CAPTURE;
               else if (tmo_hit) state_q <= NEXT;
            end
            CAPTURE: begin
               if (wr_en && k_last) state_q <= NEXT;
            end
            NEXT: begin
               if (phase_last) begin
                  state_q   <= HANDOFF;
                  w_request <= 1'b1;
               end else begin
                  state_q <= ARM;
               end
            end
            HANDOFF: begin
               if (w_frame_ready) begin
                  state_q   <= RELEASE;
                  w_request <= 1'b0;
               end
            end
            RELEASE: begin
               if (!w_frame_ready) begin
                  frame_done <= 1'b1;
                  state_q    <= start ? ARM : IDLE;
                  busy       <= start;
               end
            end
            default: begin
               state_q   <= IDLE;
               busy      <= 1'b0;
               w_request <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ets_capture_sequencer.sv
// Self-checking bench for ets_capture_sequencer with SAMPLES=4, PHASES=2.
module tb_ets_capture_sequencer;

   localparam int unsigned S  = 4;
   localparam int unsigned P  = 2;
   localparam int unsigned AW = 5;

   logic clk = 1'b0;
   logic reset, start, trigger, sample_valid, w_frame_ready;
   logic [2:0] w_buffer_id;
   logic w_request, wr_en, busy, frame_done, id_error;
   logic [AW-1:0] wr_addr;
   logic [$clog2(P)-1:0] phase;
`ifdef ETS_TRIG_TIMEOUT_EN
   logic trig_timeout;
`endif

   int vectors = 0;
   int miscompares = 0;
   int unsigned wq[$];

   always #5 clk = ~clk;

   ets_capture_sequencer #(
      .SAMPLES(S), .PHASES(P), .ADDR_W(AW), .TIMEOUT_CYCLES(1000)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .trigger(trigger),
      .sample_valid(sample_valid), .w_buffer_id(w_buffer_id),
      .w_frame_ready(w_frame_ready), .w_request(w_request), .wr_en(wr_en),
      .wr_addr(wr_addr), .phase(phase), .busy(busy), .frame_done(frame_done),
      .id_error(id_error)
`ifdef ETS_TRIG_TIMEOUT_EN
      , .trig_timeout(trig_timeout)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs after the edge, then log any write the RAM will take.
   task automatic cyc(input logic st, input logic trg, input logic sv, input logic rdy);
      @(posedge clk);
      #2;
      start = st; trigger = trg; sample_valid = sv; w_frame_ready = rdy;
      #2;
      if (wr_en === 1'b1) wq.push_back(32'(wr_addr));
   endtask

   // Reference address of sample k of the burst at phase p in buffer idx.
   function automatic int unsigned ref_addr(input int unsigned idx, input int unsigned k,
                                            input int unsigned p);
      return idx * S * P + k * P + p;
   endfunction

   task automatic burst(input int unsigned idx, input int unsigned p, input logic st);
      int unsigned n;
      wq.delete();
      chk("phase_at_arm", 32'(phase), p);
      cyc(st, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      chk("no_wr_on_trigger", 32'(wr_en), 0);
      n = 0;
      while (wq.size() < S && n < 100) begin
         cyc(st, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b0);
         n++;
      end
      chk("burst_write_count", wq.size(), S);
      for (int k = 0; k < wq.size() && k < int'(S); k++)
         chk("burst_addr", wq[k], ref_addr(idx, k, p));
      cyc(st, 1'b0, 1'b1, 1'b0);
      chk("no_wr_after_burst", 32'(wr_en), 0);
      chk("wreq_not_early", 32'(w_request), 0);
      cyc(st, 1'b0, 1'b1, 1'b0);
      chk("wreq_latency", 32'(w_request), (p == P - 1) ? 1 : 0);
      chk("phase_after_burst", 32'(phase), (p == P - 1) ? p : p + 1);
      chk("burst_write_total", wq.size(), S);
   endtask

   task automatic handoff(input int unsigned nwait, input logic st, input logic [2:0] next_id,
                          input logic exp_id_err);
      int unsigned fd;
      int unsigned r;
      fd = 0;
      w_buffer_id = next_id;
      for (int i = 0; i < int'(nwait); i++) begin
         cyc(st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
         chk("wreq_held", 32'(w_request), 1);
         chk("no_wr_in_handoff", 32'(wr_en), 0);
      end
      r = $urandom_range(1, 3);
      for (int i = 0; i < int'(r); i++) cyc(st, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cyc(st, 1'b0, 1'b0, 1'b0);
         if (i == 0) chk("wreq_dropped", 32'(w_request), 0);
         if (frame_done === 1'b1) fd++;
      end
      chk("frame_done_once", fd, 1);
      chk("busy_after_frame", 32'(busy), 32'(st));
      chk("phase_reset", 32'(phase), 0);
      chk("id_error_level", 32'(id_error), 32'(exp_id_err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned idx;
      reset = 1'b1; start = 1'b0; trigger = 1'b0; sample_valid = 1'b1;
      w_frame_ready = 1'b0; w_buffer_id = 3'b001;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_w_request", 32'(w_request), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_id_error", 32'(id_error), 0);
      chk("rst_phase", 32'(phase), 0);
      chk("rst_wr_addr", 32'(wr_addr), 0);
      sample_valid = 1'b0;
      reset = 1'b0;

      // Idle: trigger and samples ignored without start.
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      chk("idle_no_wr", 32'(wr_en), 0);
      chk("idle_not_busy", 32'(busy), 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("busy_armed", 32'(busy), 1);

      // Frames 1 and 2 into buffers 0 and 1.
      burst(0, 0, 1'b1);
      burst(0, 1, 1'b1);
      handoff(10, 1'b1, 3'b010, 1'b0);
      burst(1, 0, 1'b1);
      burst(1, 1, 1'b1);
      handoff(3, 1'b1, 3'b011, 1'b1);

      // Invalid buffer ID: no capture until a legal ID is sampled.
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'(i % 2), 1'b1, 1'b0);
         chk("bad_id_no_wr", 32'(wr_en), 0);
      end
      w_buffer_id = 3'b100;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      burst(2, 0, 1'b1);
      burst(2, 1, 1'b0);
      handoff(2, 1'b0, 3'b001, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      chk("idle_after_stop_no_wr", 32'(wr_en), 0);

      // Randomized frames with random buffer choice and handoff wait.
      for (int f = 0; f < 3; f++) begin
         idx = $urandom_range(0, 2);
         w_buffer_id = 3'b001 << idx;
         cyc(1'b1, 1'b0, 1'b0, 1'b0);
         cyc(1'b1, 1'b0, 1'b0, 1'b0);
         for (int unsigned p = 0; p < P; p++) burst(idx, p, 1'b1);
         handoff($urandom_range(0, 6), 1'b0, 3'b001, 1'b1);
      end

      // Reset in the middle of the second burst.
      w_buffer_id = 3'b001;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      burst(0, 0, 1'b1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("pre_reset_wr_en", 32'(wr_en), 1);
      chk("pre_reset_phase", 32'(phase), 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_wr_en", 32'(wr_en), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_phase", 32'(phase), 0);
      chk("mid_rst_wr_addr", 32'(wr_addr), 0);
      chk("mid_rst_id_error", 32'(id_error), 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      burst(0, 0, 1'b1);
      burst(0, 1, 1'b1);

      // Reset during handoff drops the request at once.
      reset = 1'b1;
      #1;
      chk("rst_drops_wreq", 32'(w_request), 0);
      #10;
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
